// File: rtl/cpu7_exu_lsq_if.sv
// Request/response bundle between the ECL/LSU/data-memory side and the outstanding-request queue.
// The master drives requests, responses and decode sources; the slave (the queue) drives status.
interface cpu7_exu_lsq_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GRLEN = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             ecl_lsq_alloc_e;
    logic             ecl_lsq_wr_e;
    logic [4:0]       ecl_lsq_rd_e;
    logic             ecl_lsq_wen_e;
    logic [GRLEN-1:0] ecl_lsq_pc_e;
    logic             ecl_lsq_flush;
    logic             data_data_ok;
    logic [GRLEN-1:0] data_rdata;
    logic             data_exception;
    logic [5:0]       data_excode;
    logic [4:0]       ecl_lsq_rs1_d;
    logic [4:0]       ecl_lsq_rs2_d;

    logic             lsq_ecl_raw_stall_d;
    logic             lsq_ecl_valid_m;
    logic [GRLEN-1:0] lsq_ecl_rdata_m;
    logic [4:0]       lsq_ecl_rd_m;
    logic             lsq_ecl_wen_m;
    logic [GRLEN-1:0] lsq_ecl_pc_m;
    logic             lsq_ecl_exc_m;
    logic [5:0]       lsq_ecl_excode_m;
    logic             lsq_full;
    logic             lsq_empty;
    logic [CW-1:0]    lsq_count;
    logic             lsq_err;

    modport master (
        output ecl_lsq_alloc_e, ecl_lsq_wr_e, ecl_lsq_rd_e, ecl_lsq_wen_e, ecl_lsq_pc_e,
               ecl_lsq_flush, data_data_ok, data_rdata, data_exception, data_excode,
               ecl_lsq_rs1_d, ecl_lsq_rs2_d,
        input  lsq_ecl_raw_stall_d, lsq_ecl_valid_m, lsq_ecl_rdata_m, lsq_ecl_rd_m,
               lsq_ecl_wen_m, lsq_ecl_pc_m, lsq_ecl_exc_m, lsq_ecl_excode_m,
               lsq_full, lsq_empty, lsq_count, lsq_err
    );

    modport slave (
        input  ecl_lsq_alloc_e, ecl_lsq_wr_e, ecl_lsq_rd_e, ecl_lsq_wen_e, ecl_lsq_pc_e,
               ecl_lsq_flush, data_data_ok, data_rdata, data_exception, data_excode,
               ecl_lsq_rs1_d, ecl_lsq_rs2_d,
        output lsq_ecl_raw_stall_d, lsq_ecl_valid_m, lsq_ecl_rdata_m, lsq_ecl_rd_m,
               lsq_ecl_wen_m, lsq_ecl_pc_m, lsq_ecl_exc_m, lsq_ecl_excode_m,
               lsq_full, lsq_empty, lsq_count, lsq_err
    );
endinterface

// File: rtl/cpu7_exu_lsq.sv
// Outstanding load/store request queue: matches in-order data responses to rd/pc,
// raises RAW stalls against pending loads and cancels in-flight requests on flush.
module cpu7_exu_lsq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned GRLEN = 32
) (
    input logic            clk,
    input logic            resetn,
    cpu7_exu_lsq_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] valid_q, valid_d, cancel_q, cancel_d;
    logic [DEPTH-1:0] wr_q, wr_d, wen_q, wen_d;
    logic [4:0]       rd_q [DEPTH];
    logic [4:0]       rd_d [DEPTH];
    logic [GRLEN-1:0] pc_q [DEPTH];
    logic [GRLEN-1:0] pc_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic             valid_m_q, valid_m_d, wen_m_q, wen_m_d, exc_m_q, exc_m_d;
    logic [GRLEN-1:0] rdata_m_q, rdata_m_d, pc_m_q, pc_m_d;
    logic [4:0]       rd_m_q, rd_m_d;
    logic [5:0]       excode_m_q, excode_m_d;

    logic full, empty, push, pop, head_live, stall;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    // Full is judged before any same-cycle pop, so an alloc never overwrites the head.
    assign push      = bus.ecl_lsq_alloc_e & ~full;
    assign pop       = bus.data_data_ok & ~empty;
    assign head_live = ~cancel_q[head_q] & ~bus.ecl_lsq_flush;

    always_comb begin
        valid_d  = valid_q;
        cancel_d = cancel_q;
        wr_d     = wr_q;
        wen_d    = wen_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        head_d   = head_q;
        tail_d   = tail_q;
        if (bus.ecl_lsq_flush) begin
            cancel_d = cancel_q | valid_q;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q]  = 1'b1;
            cancel_d[tail_q] = 1'b0;
            wr_d[tail_q]     = bus.ecl_lsq_wr_e;
            wen_d[tail_q]    = bus.ecl_lsq_wen_e;
            rd_d[tail_q]     = bus.ecl_lsq_rd_e;
            pc_d[tail_q]     = bus.ecl_lsq_pc_e;
            tail_d           = tail_q + 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
        err_d   = err_q | (bus.ecl_lsq_alloc_e & full) | (bus.data_data_ok & empty);
    end

    always_comb begin
        valid_m_d  = pop & head_live;
        rdata_m_d  = rdata_m_q;
        rd_m_d     = rd_m_q;
        pc_m_d     = pc_m_q;
        wen_m_d    = wen_m_q;
        exc_m_d    = exc_m_q;
        excode_m_d = excode_m_q;
        if (pop && head_live) begin
            rdata_m_d  = bus.data_rdata;
            rd_m_d     = rd_q[head_q];
            pc_m_d     = pc_q[head_q];
            wen_m_d    = wen_q[head_q] & ~wr_q[head_q] & ~bus.data_exception;
            exc_m_d    = bus.data_exception;
            excode_m_d = bus.data_excode;
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (valid_q[i] && !cancel_q[i] && wen_q[i] && !wr_q[i]) begin
                if ((bus.ecl_lsq_rs1_d != 5'd0 && bus.ecl_lsq_rs1_d == rd_q[i]) ||
                    (bus.ecl_lsq_rs2_d != 5'd0 && bus.ecl_lsq_rs2_d == rd_q[i])) begin
                    stall = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q    <= '0;
            cancel_q   <= '0;
            wr_q       <= '0;
            wen_q      <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                rd_q[i] <= '0;
                pc_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            valid_m_q  <= 1'b0;
            rdata_m_q  <= '0;
            rd_m_q     <= '0;
            pc_m_q     <= '0;
            wen_m_q    <= 1'b0;
            exc_m_q    <= 1'b0;
            excode_m_q <= '0;
        end else begin
            valid_q    <= valid_d;
            cancel_q   <= cancel_d;
            wr_q       <= wr_d;
            wen_q      <= wen_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
            valid_m_q  <= valid_m_d;
            rdata_m_q  <= rdata_m_d;
            rd_m_q     <= rd_m_d;
            pc_m_q     <= pc_m_d;
            wen_m_q    <= wen_m_d;
            exc_m_q    <= exc_m_d;
            excode_m_q <= excode_m_d;
        end
    end

    assign bus.lsq_ecl_raw_stall_d = stall;
    assign bus.lsq_ecl_valid_m     = valid_m_q;
    assign bus.lsq_ecl_rdata_m     = rdata_m_q;
    assign bus.lsq_ecl_rd_m        = rd_m_q;
    assign bus.lsq_ecl_wen_m       = wen_m_q;
    assign bus.lsq_ecl_pc_m        = pc_m_q;
    assign bus.lsq_ecl_exc_m       = exc_m_q;
    assign bus.lsq_ecl_excode_m    = excode_m_q;
    assign bus.lsq_full            = full;
    assign bus.lsq_empty           = empty;
    assign bus.lsq_count           = count_q;
    assign bus.lsq_err             = err_q;
endmodule

// File: tb/tb_cpu7_exu_lsq.sv
// Directed bench for cpu7_exu_lsq (DEPTH=4, GRLEN=32) with hand-computed expectations.
module tb_cpu7_exu_lsq;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cpu7_exu_lsq_if #(.DEPTH(4), .GRLEN(32)) bus ();

    cpu7_exu_lsq #(.DEPTH(4), .GRLEN(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.ecl_lsq_alloc_e = 1'b0;
        bus.ecl_lsq_wr_e    = 1'b0;
        bus.ecl_lsq_rd_e    = 5'd0;
        bus.ecl_lsq_wen_e   = 1'b0;
        bus.ecl_lsq_pc_e    = '0;
        bus.ecl_lsq_flush   = 1'b0;
        bus.data_data_ok    = 1'b0;
        bus.data_rdata      = '0;
        bus.data_exception  = 1'b0;
        bus.data_excode     = 6'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic alloc(input logic wr, input logic [4:0] rd, input logic wen,
                         input logic [31:0] pc);
        bus.ecl_lsq_alloc_e = 1'b1;
        bus.ecl_lsq_wr_e    = wr;
        bus.ecl_lsq_rd_e    = rd;
        bus.ecl_lsq_wen_e   = wen;
        bus.ecl_lsq_pc_e    = pc;
    endtask

    task automatic resp(input logic [31:0] rdata, input logic exc, input logic [5:0] code);
        bus.data_data_ok   = 1'b1;
        bus.data_rdata     = rdata;
        bus.data_exception = exc;
        bus.data_excode    = code;
    endtask

    initial begin
        idle();
        bus.ecl_lsq_rs1_d = 5'd0;
        bus.ecl_lsq_rs2_d = 5'd0;
        #12;
        check("rst_count", 64'(bus.lsq_count), 64'd0);
        check("rst_empty", 64'(bus.lsq_empty), 64'd1);
        check("rst_full", 64'(bus.lsq_full), 64'd0);
        check("rst_err", 64'(bus.lsq_err), 64'd0);
        check("rst_valid_m", 64'(bus.lsq_ecl_valid_m), 64'd0);
        check("rst_stall", 64'(bus.lsq_ecl_raw_stall_d), 64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Single load
        alloc(1'b0, 5'd5, 1'b1, 32'h1c00_0000);
        tick();
        check("ld_count", 64'(bus.lsq_count), 64'd1);
        tick();
        resp(32'hdead_beef, 1'b0, 6'd0);
        tick();
        check("ld_valid", 64'(bus.lsq_ecl_valid_m), 64'd1);
        check("ld_rd", 64'(bus.lsq_ecl_rd_m), 64'd5);
        check("ld_wen", 64'(bus.lsq_ecl_wen_m), 64'd1);
        check("ld_rdata", 64'(bus.lsq_ecl_rdata_m), 64'hdead_beef);
        check("ld_pc", 64'(bus.lsq_ecl_pc_m), 64'h1c00_0000);
        tick();
        check("ld_valid_once", 64'(bus.lsq_ecl_valid_m), 64'd0);
        check("ld_empty", 64'(bus.lsq_empty), 64'd1);

        // Fill, overflow, drain
        for (int i = 1; i <= 4; i++) begin
            alloc(1'b0, 5'(i), 1'b1, 32'h100 + 32'(i));
            tick();
        end
        check("fill_full", 64'(bus.lsq_full), 64'd1);
        check("fill_count", 64'(bus.lsq_count), 64'd4);
        check("fill_err0", 64'(bus.lsq_err), 64'd0);
        alloc(1'b0, 5'd20, 1'b1, 32'h200);
        tick();
        check("ovf_err", 64'(bus.lsq_err), 64'd1);
        check("ovf_count", 64'(bus.lsq_count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            resp(32'h1000 + 32'(i), 1'b0, 6'd0);
            tick();
            check("drain_valid", 64'(bus.lsq_ecl_valid_m), 64'd1);
            check("drain_rd", 64'(bus.lsq_ecl_rd_m), 64'(i));
            check("drain_pc", 64'(bus.lsq_ecl_pc_m), 64'h100 + 64'(i));
        end
        check("drain_empty", 64'(bus.lsq_empty), 64'd1);

        // RAW stall
        alloc(1'b1, 5'd9, 1'b0, 32'h300);
        tick();
        bus.ecl_lsq_rs2_d = 5'd9;
        #1;
        check("raw_store", 64'(bus.lsq_ecl_raw_stall_d), 64'd0);
        alloc(1'b0, 5'd9, 1'b1, 32'h304);
        tick();
        bus.ecl_lsq_rs1_d = 5'd9;
        #1;
        check("raw_load", 64'(bus.lsq_ecl_raw_stall_d), 64'd1);
        bus.ecl_lsq_rs1_d = 5'd0;
        bus.ecl_lsq_rs2_d = 5'd0;
        #1;
        check("raw_zero", 64'(bus.lsq_ecl_raw_stall_d), 64'd0);
        resp(32'h0, 1'b0, 6'd0);
        tick();
        check("st_valid", 64'(bus.lsq_ecl_valid_m), 64'd1);
        check("st_wen", 64'(bus.lsq_ecl_wen_m), 64'd0);
        bus.ecl_lsq_rs2_d = 5'd9;
        #1;
        check("raw_rs2", 64'(bus.lsq_ecl_raw_stall_d), 64'd1);
        resp(32'h55, 1'b0, 6'd0);
        tick();
        check("raw_popped", 64'(bus.lsq_ecl_raw_stall_d), 64'd0);
        check("raw_rd_m", 64'(bus.lsq_ecl_rd_m), 64'd9);
        bus.ecl_lsq_rs2_d = 5'd0;

        // Flush
        alloc(1'b0, 5'd1, 1'b1, 32'h400);
        tick();
        alloc(1'b0, 5'd2, 1'b1, 32'h404);
        tick();
        alloc(1'b0, 5'd7, 1'b1, 32'h408);
        bus.ecl_lsq_flush = 1'b1;
        tick();
        check("fl_count", 64'(bus.lsq_count), 64'd3);
        bus.ecl_lsq_rs1_d = 5'd1;
        #1;
        check("fl_stall_cancel", 64'(bus.lsq_ecl_raw_stall_d), 64'd0);
        bus.ecl_lsq_rs1_d = 5'd7;
        #1;
        check("fl_stall_new", 64'(bus.lsq_ecl_raw_stall_d), 64'd1);
        bus.ecl_lsq_rs1_d = 5'd0;
        resp(32'h1, 1'b0, 6'd0);
        tick();
        check("fl_resp1", 64'(bus.lsq_ecl_valid_m), 64'd0);
        resp(32'h2, 1'b0, 6'd0);
        tick();
        check("fl_resp2", 64'(bus.lsq_ecl_valid_m), 64'd0);
        resp(32'h7, 1'b0, 6'd0);
        tick();
        check("fl_resp3", 64'(bus.lsq_ecl_valid_m), 64'd1);
        check("fl_rd7", 64'(bus.lsq_ecl_rd_m), 64'd7);
        check("fl_empty", 64'(bus.lsq_empty), 64'd1);

        // Concurrent alloc + response, exception response
        alloc(1'b0, 5'd10, 1'b1, 32'h500);
        tick();
        alloc(1'b0, 5'd11, 1'b1, 32'h504);
        tick();
        alloc(1'b0, 5'd12, 1'b1, 32'h508);
        resp(32'hcafe_0010, 1'b0, 6'd0);
        tick();
        check("cc_count", 64'(bus.lsq_count), 64'd2);
        check("cc_rd", 64'(bus.lsq_ecl_rd_m), 64'd10);
        check("cc_rdata", 64'(bus.lsq_ecl_rdata_m), 64'hcafe_0010);
        resp(32'hcafe_0011, 1'b1, 6'h08);
        tick();
        check("exc_valid", 64'(bus.lsq_ecl_valid_m), 64'd1);
        check("exc_flag", 64'(bus.lsq_ecl_exc_m), 64'd1);
        check("exc_code", 64'(bus.lsq_ecl_excode_m), 64'h08);
        check("exc_wen", 64'(bus.lsq_ecl_wen_m), 64'd0);
        check("exc_rd", 64'(bus.lsq_ecl_rd_m), 64'd11);
        resp(32'hcafe_0012, 1'b0, 6'd0);
        tick();
        check("cc_last_rd", 64'(bus.lsq_ecl_rd_m), 64'd12);
        check("cc_last_exc", 64'(bus.lsq_ecl_exc_m), 64'd0);

        // Reset mid-run with 3 outstanding
        for (int i = 0; i < 3; i++) begin
            alloc(1'b0, 5'(13 + i), 1'b1, 32'h600);
            tick();
        end
        check("pre_rst_count", 64'(bus.lsq_count), 64'd3);
        resetn = 1'b0;
        #2;
        check("mid_rst_count", 64'(bus.lsq_count), 64'd0);
        check("mid_rst_empty", 64'(bus.lsq_empty), 64'd1);
        check("mid_rst_valid", 64'(bus.lsq_ecl_valid_m), 64'd0);
        check("mid_rst_err", 64'(bus.lsq_err), 64'd0);
        resetn = 1'b1;
        resp(32'h9, 1'b0, 6'd0);
        tick();
        check("unf_err", 64'(bus.lsq_err), 64'd1);
        check("unf_valid", 64'(bus.lsq_ecl_valid_m), 64'd0);
        check("unf_count", 64'(bus.lsq_count), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
